// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: lane steering, byte enables, sign extension, ack timeout.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN: misaligned addresses return rsp_err=1 instead of being rounded down.
module mem_access_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [1:0]          rsp_err
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [15:0]       busy_cnt;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [LB-1:0]     off_q;

  logic [2:0]        low_mask;
  logic [7:0]        lane_mask;
  logic [ADDR_W-1:0] eff_addr;
  logic [LB-1:0]     off_next;
  logic [NB-1:0]     be_next;
  logic [DATA_W-1:0] wdata_rep;
  logic              illegal;

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_data;
  logic              ext;
  int                nbits;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  // Request-side decode; the rounded-down address only matters when trapping is disabled.
  always_comb begin
    low_mask  = 3'b000;
    lane_mask = 8'h01;
    wdata_rep = req_wdata;
    case (req_size)
      2'd0: begin low_mask = 3'b000; lane_mask = 8'h01; wdata_rep = {NB{req_wdata[7:0]}};      end
      2'd1: begin low_mask = 3'b001; lane_mask = 8'h03; wdata_rep = {(NB/2){req_wdata[15:0]}}; end
      2'd2: begin low_mask = 3'b011; lane_mask = 8'h0F; wdata_rep = {(NB/4){req_wdata[31:0]}}; end
      default: begin low_mask = 3'b111; lane_mask = 8'hFF; wdata_rep = req_wdata;                end
    endcase
    eff_addr = req_addr & ~ADDR_W'(low_mask);
    off_next = eff_addr[LB-1:0];
    be_next  = NB'(lane_mask << off_next);
    illegal  = (req_size == 2'd3) && (DATA_W == 32);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    illegal  = illegal || (|(req_addr[2:0] & low_mask));
`endif
  end

  // Load steering: shift the addressed lanes down, then extend above the access width.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    nbits   = 8 << size_q;
    if (nbits > DATA_W) nbits = DATA_W;
    case (size_q)
      2'd0:    ext = !uns_q && shifted[7];
      2'd1:    ext = !uns_q && shifted[15];
      2'd2:    ext = !uns_q && shifted[31];
      default: ext = !uns_q && shifted[DATA_W-1];
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      load_data[i] = (i < nbits) ? shifted[i] : ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy_cnt  <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'd0;
      off_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            uns_q    <= req_unsigned;
            size_q   <= req_size;
            off_q    <= off_next;
            busy_cnt <= '0;
            rsp_data <= '0;
            rsp_err  <= 2'd0;
            if (illegal) begin
              state   <= S_RESP;
              rsp_err <= 2'd1;
            end else begin
              state     <= S_BUSY;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {eff_addr[ADDR_W-1:LB], {LB{1'b0}}};
              mem_wdata <= wdata_rep;
              mem_be    <= be_next;
            end
          end
        end
        S_BUSY: begin
          // An ack in the final counted cycle still wins over the timeout.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            state    <= S_RESP;
            rsp_data <= we_q ? '0 : load_data;
            rsp_err  <= 2'd0;
          end else if (busy_cnt == TO_LAST) begin
            mem_req  <= 1'b0;
            state    <= S_RESP;
            rsp_data <= '0;
            rsp_err  <= 2'd2;
          end else begin
            busy_cnt <= busy_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data-path width; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, maximum number of BUSY cycles to wait for mem_ack; legal range is 1..65535.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit: access request present.
REQ-007 SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2 bits: 0 = byte, 1 = halfword, 2 = word, 3 = doubleword (legal only when DATA_W=64).
REQ-010 SHALL have port req_unsigned, input, 1 bit: loads zero-extend when 1 and sign-extend when 0.
REQ-011 SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-012 SHALL have port req_wdata, input, DATA_W bits: store data, right-justified.
REQ-013 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, DATA_W) and mem_be (out, DATA_W/8): the memory-side request.
REQ-014 SHALL have ports mem_ack (in, 1) and mem_rdata (in, DATA_W): the memory-side completion; mem_rdata is valid only while mem_ack=1.
REQ-015 SHALL have ports rsp_valid (out, 1), rsp_data (out, DATA_W) and rsp_err (out, 2): the response, with rsp_err 0 = ok, 1 = misaligned/illegal, 2 = timeout.

Function
REQ-016 SHALL implement the FSM states IDLE, BUSY and RESP; req_ready=1 only in IDLE.
REQ-017 SHALL accept a request when req_valid and req_ready are both 1, registering all req_* fields on that edge (cycle N).
REQ-018 SHALL move from IDLE to BUSY on a legal accept, with mem_req=1 from cycle N+1.
REQ-019 SHALL hold mem_req, mem_we, mem_addr, mem_wdata and mem_be stable while in BUSY.
REQ-020 SHALL ignore mem_ack outside BUSY.
REQ-021 SHALL drive mem_addr as the captured address with the low log2(DATA_W/8) bits cleared.
REQ-022 SHALL compute lane offset off = captured addr[log2(DATA_W/8)-1:0] and mem_be = (2^(2^size) - 1) << off.
REQ-023 SHALL replicate the low 2^size bytes of req_wdata across all lanes of mem_wdata.
REQ-024 SHALL, on mem_ack in BUSY at cycle M, drop mem_req at M+1, enter RESP and drive rsp_valid=1 for exactly one cycle (M+1).
REQ-025 SHALL, for a load, set rsp_data to the 2^size bytes of mem_rdata starting at byte off, sign- or zero-extended to DATA_W per req_unsigned; a full-width access SHALL pass mem_rdata through unmodified.
REQ-026 SHALL, for a store, set rsp_data=0 and rsp_err=0.
REQ-027 SHALL count BUSY cycles and, if mem_ack has not arrived by the TIMEOUT_CYC-th cycle, drop mem_req and respond with rsp_err=2 and rsp_data=0.
REQ-028 SHALL give mem_ack priority over timeout when both occur in the same cycle.
REQ-029 SHALL treat req_size=3 with DATA_W=32 as illegal: no mem_req, IDLE to RESP, rsp_valid at N+1 with rsp_err=1 and rsp_data=0.
REQ-030 SHALL return from RESP to IDLE after one cycle; minimum initiation interval is 3 cycles.

Reset
REQ-031 SHALL asynchronously force, on rst=1, the FSM to IDLE, the timeout counter to 0, and req_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, rsp_valid=0, rsp_data=0 and rsp_err=0.
REQ-032 SHALL discard any in-flight request on reset mid-operation and produce no response for it.

Configuration
REQ-033 SHALL, with MEM_ACCESS_MISALIGN_TRAP_EN defined, treat any address not a multiple of 2^size as misaligned: no mem_req, rsp_valid at N+1 with rsp_err=1 and rsp_data=0.
REQ-034 SHALL, with MEM_ACCESS_MISALIGN_TRAP_EN undefined, clear the low size bits of the address and perform the access at that address; misalignment SHALL never produce rsp_err=1.

Verification
REQ-035 SHALL cover: DATA_W=32, load byte, signed, addr 0x1003, mem_rdata 0x80FF_FF00, ack after 2 cycles -> rsp_data 0xFFFF_FF80, rsp_err 0.
REQ-036 SHALL cover: load halfword, unsigned, addr 0x2002, mem_rdata 0xBEEF_1234 -> rsp_data 0x0000_BEEF.
REQ-037 SHALL cover: store byte 0xA5 to addr 0x0001 -> mem_addr 0x0000, mem_be 4'b0010, mem_wdata 0xA5A5_A5A5.
REQ-038 SHALL cover: TIMEOUT_CYC=4 with no ack -> mem_req drops after 4 BUSY cycles, rsp_err 2; a separate case with ack on the 4th cycle -> rsp_err 0.
REQ-039 SHALL cover: word load at addr 0x0006, with and without MEM_ACCESS_MISALIGN_TRAP_EN -> rsp_err 1 with no mem_req, versus mem_addr 0x0004 with rsp_err 0.
REQ-040 SHALL cover: rst asserted while in BUSY -> mem_req 0 immediately, no rsp_valid, req_ready 1.
